// File: rtl/m_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : m_multicycle_ctrl
// Brief    : Moore control FSM for a multi-cycle RV32I datapath (shared
//            instruction/data memory, single ALU, IR and PC). It drives every
//            per-cycle strobe and mux select, and keeps a retired-instruction
//            counter.
//            Optional feature macro: MC_JAL_EN builds the JAL state. Without
//            it, opcode 1101111 is treated as unsupported and halts.
// Revision : 1.0 - initial release
// ============================================================================
module m_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic [6:0]       w_opcode,
    input  logic             w_zero,
    output logic             w_pc_write,
    output logic             w_adr_src,
    output logic             w_mem_write,
    output logic             w_ir_write,
    output logic [1:0]       w_result_src,
    output logic [1:0]       w_alu_src_a,
    output logic [1:0]       w_alu_src_b,
    output logic [1:0]       w_alu_op,
    output logic             w_reg_write,
    output logic             w_halt,
    output logic [3:0]       w_state,
    output logic [CNT_W-1:0] w_instret
);

    // State encoding (also exported on w_state for debug)
    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECR    = 4'd6;
    localparam logic [3:0] c_ALUWB    = 4'd7;
    localparam logic [3:0] c_EXECI    = 4'd8;
    localparam logic [3:0] c_JAL      = 4'd9;
    localparam logic [3:0] c_BEQ      = 4'd10;
    localparam logic [3:0] c_HALT     = 4'd15;

    // Opcodes recognised in DECODE / MEMADR
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_IALU  = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    logic [3:0]       r_state;
    logic [3:0]       w_state_nxt;
    logic             w_pc_update;
    logic             w_branch;
    logic             w_retire;
    logic [CNT_W-1:0] r_instret;

    // State register; reset wins over every transition, including HALT
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded (Moore) outputs
    always_comb begin
        w_state_nxt  = c_HALT;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_reg_write  = 1'b0;
        w_halt       = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            c_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_update  = 1'b1;
                w_state_nxt  = c_DECODE;
            end
            c_DECODE: begin
                // ALU precomputes OldPC + imm as a branch/jump target
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (w_opcode)
                    c_OP_LOAD, c_OP_STORE: w_state_nxt = c_MEMADR;
                    c_OP_RTYPE:            w_state_nxt = c_EXECR;
                    c_OP_IALU:             w_state_nxt = c_EXECI;
                    c_OP_BEQ:              w_state_nxt = c_BEQ;
`ifdef MC_JAL_EN
                    c_OP_JAL:              w_state_nxt = c_JAL;
`endif
                    default:               w_state_nxt = c_HALT;
                endcase
            end
            c_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_state_nxt = (w_opcode == c_OP_LOAD) ? c_MEMREAD : c_MEMWRITE;
            end
            c_MEMREAD: begin
                w_adr_src   = 1'b1;
                w_state_nxt = c_MEMWB;
            end
            c_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_state_nxt  = c_FETCH;
            end
            c_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = c_FETCH;
            end
            c_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
                w_state_nxt = c_ALUWB;
            end
            c_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_state_nxt = c_ALUWB;
            end
            c_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = c_FETCH;
            end
`ifdef MC_JAL_EN
            c_JAL: begin
                // rd <= OldPC + 4 via ALU; PC takes the target from ALUOut
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_update = 1'b1;
                w_state_nxt = c_ALUWB;
            end
`endif
            c_BEQ: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = c_FETCH;
            end
            c_HALT: begin
                w_halt      = 1'b1;
                w_state_nxt = c_HALT;
            end
            default: begin
                // Unused codes (and JAL when not built) fall into HALT
                w_state_nxt = c_HALT;
            end
        endcase
    end

    // Retired-instruction counter, bumped on the edge leaving a final state
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign w_pc_write = w_pc_update | (w_branch & w_zero);
    assign w_state    = r_state;
    assign w_instret  = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_m_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_multicycle_ctrl
// Brief    : Table-driven self-checking bench for m_multicycle_ctrl. Honours
//            MC_JAL_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_multicycle_ctrl;

    logic       w_clk = 1'b0;
    logic       w_rst;
    logic [6:0] w_opcode;
    logic       w_zero;
    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_halt;
    logic [3:0] w_state;
    logic [3:0] w_instret;

    m_multicycle_ctrl #(.CNT_W(4)) u_dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .w_opcode     (w_opcode),
        .w_zero       (w_zero),
        .w_pc_write   (w_pc_write),
        .w_adr_src    (w_adr_src),
        .w_mem_write  (w_mem_write),
        .w_ir_write   (w_ir_write),
        .w_result_src (w_result_src),
        .w_alu_src_a  (w_alu_src_a),
        .w_alu_src_b  (w_alu_src_b),
        .w_alu_op     (w_alu_op),
        .w_reg_write  (w_reg_write),
        .w_halt       (w_halt),
        .w_state      (w_state),
        .w_instret    (w_instret)
    );

    always #5 w_clk = ~w_clk;

    // Expected per-state outputs; pc_write is pcu | (br & zero)
    typedef struct packed {
        logic       pcu;
        logic       br;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       rw;
        logic       h;
    } out_t;

    // One instruction: opcode, zero in BEQ, length in states, state sequence
    typedef struct packed {
        logic [6:0]      opcode;
        logic            zero;
        logic [2:0]      len;
        logic [5:0][3:0] seq;
    } vec_t;

    out_t       out_tab [16];
    vec_t       vecs [8];
    int         n_vecs;
    int         n_pass  = 0;
    int         n_total = 0;
    logic [3:0] exp_cnt;

    function automatic out_t mk_out(input logic pcu, br, adr, mw, irw,
                                    input logic [1:0] rs, a, b, op,
                                    input logic rw, h);
        out_t o;
        o.pcu = pcu; o.br = br; o.adr = adr; o.mw = mw; o.irw = irw;
        o.rs = rs; o.a = a; o.b = b; o.op = op; o.rw = rw; o.h = h;
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic [6:0] opc, input logic z,
                                    input logic [2:0] len,
                                    input logic [3:0] s0, s1, s2, s3, s4);
        vec_t v;
        v.opcode = opc; v.zero = z; v.len = len;
        v.seq = '0;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Compare every output against the table row for the given state
    task automatic chk_outputs(input string name, input logic [3:0] st, input logic z);
        out_t       e;
        logic [13:0] act, exp;
        e   = out_tab[st];
        exp = {e.pcu | (e.br & z), e.adr, e.mw, e.irw, e.rs, e.a, e.b, e.op, e.rw, e.h};
        act = {w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_result_src,
               w_alu_src_a, w_alu_src_b, w_alu_op, w_reg_write, w_halt};
        chk(name, 32'(act), 32'(exp));
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        tick();
        tick();
        w_rst   = 1'b0;
        exp_cnt = 4'd0;
        #1;
        chk("reset_state", 32'(w_state), 32'd0);
        chk("reset_instret", 32'(w_instret), 32'd0);
        chk_outputs("reset_outputs", 4'd0, 1'b0);
    endtask

    // Walk one instruction; zero is driven opposite to the BEQ value
    // outside BEQ to show it is ignored there
    task automatic run_vec(input vec_t v, input string name);
        for (int k = 0; k < int'(v.len); k++) begin
            w_opcode = v.opcode;
            w_zero   = (v.seq[k] == 4'd10) ? v.zero : ~v.zero;
            #1;
            chk({name, "_state"}, 32'(w_state), 32'(v.seq[k]));
            chk_outputs({name, "_out"}, v.seq[k], w_zero);
            tick();
        end
        exp_cnt = exp_cnt + 4'd1;
        chk({name, "_end_state"}, 32'(w_state), 32'd0);
        chk({name, "_instret"}, 32'(w_instret), 32'(exp_cnt));
    endtask

    // Unsupported opcode: 0,1,15 then hold HALT for 10 cycles, then reset
    task automatic run_halt(input logic [6:0] opc, input string name);
        logic [3:0] seq [3];
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd15;
        w_opcode = opc;
        w_zero   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk({name, "_state"}, 32'(w_state), 32'(seq[k]));
            chk_outputs({name, "_out"}, seq[k], w_zero);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            w_opcode = 7'b0000011;
            w_zero   = k[0];
            #1;
            chk({name, "_hold_state"}, 32'(w_state), 32'd15);
            chk({name, "_hold_halt"}, 32'(w_halt), 32'd1);
            chk({name, "_hold_pcw"}, 32'(w_pc_write), 32'd0);
            tick();
        end
        chk({name, "_hold_instret"}, 32'(w_instret), 32'(exp_cnt));
        do_reset();
    endtask

    initial begin
        // Output table (unlisted states stay all-zero)
        for (int i = 0; i < 16; i++) out_tab[i] = '0;
        //                    pcu br adr mw irw rs     a      b      op     rw h
        out_tab[0]  = mk_out(1, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
        out_tab[1]  = mk_out(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0);
        out_tab[2]  = mk_out(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
        out_tab[3]  = mk_out(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        out_tab[4]  = mk_out(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
        out_tab[5]  = mk_out(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        out_tab[6]  = mk_out(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
        out_tab[7]  = mk_out(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        out_tab[8]  = mk_out(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0);
        out_tab[9]  = mk_out(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);
        out_tab[10] = mk_out(0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
        out_tab[15] = mk_out(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);

        // Instruction vectors
        vecs[0] = mk_vec(7'b0000011, 1'b0, 3'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);  // lw
        vecs[1] = mk_vec(7'b0100011, 1'b0, 3'd4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0);  // sw
        vecs[2] = mk_vec(7'b0110011, 1'b0, 3'd4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0);  // R-type
        vecs[3] = mk_vec(7'b0010011, 1'b0, 3'd4, 4'd0, 4'd1, 4'd8, 4'd7, 4'd0);  // I-ALU
        vecs[4] = mk_vec(7'b1100011, 1'b1, 3'd3, 4'd0, 4'd1, 4'd10, 4'd0, 4'd0); // beq taken
        vecs[5] = mk_vec(7'b1100011, 1'b0, 3'd3, 4'd0, 4'd1, 4'd10, 4'd0, 4'd0); // beq not taken
        n_vecs = 6;
`ifdef MC_JAL_EN
        vecs[6] = mk_vec(7'b1101111, 1'b0, 3'd4, 4'd0, 4'd1, 4'd9, 4'd7, 4'd0);  // jal
        n_vecs = 7;
`endif

        w_rst    = 1'b1;
        w_opcode = 7'b0;
        w_zero   = 1'b0;
        exp_cnt  = 4'd0;

        do_reset();

        for (int i = 0; i < n_vecs; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Unsupported opcodes and reset out of HALT
        run_halt(7'b0000000, "op_zero");
        run_halt(7'b1111111, "op_ones");
`ifndef MC_JAL_EN
        run_halt(7'b1101111, "jal_off");
`endif

        // Counter wrap: 17 addi on a 4-bit counter leaves 1
        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[3], "addi");
        end
        chk("wrap_instret", 32'(w_instret), 32'd1);

        // Reset mid-instruction (in MEMREAD) returns to FETCH, clears count
        w_opcode = 7'b0000011;
        tick();
        tick();
        tick();
        chk("mid_state", 32'(w_state), 32'd3);
        w_rst = 1'b1;
        tick();
        w_rst = 1'b0;
        chk("mid_rst_state", 32'(w_state), 32'd0);
        chk("mid_rst_instret", 32'(w_instret), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
